// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. It is a circular buffer that takes up to
// two fetched instructions per cycle and presents the two oldest to decode.
module inst_queue #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              flush_cause,
   input  logic [31:0]       ex_pc_i,
   input  logic              valid1_i,
   input  logic              valid2_i,
   input  logic [31:0]       inst1_i,
   input  logic [31:0]       inst2_i,
   input  logic [31:0]       pc1_i,
   output logic              full_o,
   input  logic              stall_id,
   input  logic              issue_mode_i,
   output logic [31:0]       inst1_o,
   output logic [31:0]       inst2_o,
   output logic [31:0]       pc1_o,
   output logic [31:0]       pc2_o,
   output logic              valid1_o,
   output logic              valid2_o,
   output logic [ADDR_W:0]   count_o
);
   localparam int CW = ADDR_W + 1;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [ADDR_W-1:0] head, tail;
   logic [CW-1:0]     count;
   logic [1:0]        push_n, pop_n, req_n;
   logic              do_push, keep_slot;
   entry_t            rd [2];
   logic [1:0]        rd_vld;

   assign full_o  = count > CW'(DEPTH - 2);
   assign do_push = valid1_i && !full_o && !flush;
   assign push_n  = !do_push ? 2'd0 : (valid2_i ? 2'd2 : 2'd1);
   assign req_n   = issue_mode_i ? 2'd2 : 2'd1;
   // Retire min(request, count); count < req_n implies count fits in two bits.
   assign pop_n   = (stall_id || flush) ? 2'd0 :
                    (count < CW'(req_n)) ? count[1:0] : req_n;

   // Two read ports at head and head+1; each is zeroed when its entry is absent.
   for (genvar g = 0; g < 2; g++) begin : g_rd
      assign rd_vld[g] = count > CW'(g);
      assign rd[g]     = rd_vld[g] ? mem[head + ADDR_W'(g)] : '0;
   end

   // A mispredicted branch whose delay slot is still at the head keeps that slot.
   assign keep_slot = flush_cause && rd_vld[0] && (rd[0].pc == ex_pc_i + 32'd4);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         if (keep_slot) begin
            tail  <= head + ADDR_W'(1);
            count <= CW'(1);
         end else begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end
      end else begin
         head  <= head + ADDR_W'(pop_n);
         tail  <= tail + ADDR_W'(push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[tail] <= '{inst: inst1_i, pc: pc1_i};
         if (valid2_i)
            mem[tail + ADDR_W'(1)] <= '{inst: inst2_i, pc: pc1_i + 32'd4};
      end
   end

   assign valid1_o = rd_vld[0];
   assign valid2_o = rd_vld[1];
   assign inst1_o  = rd[0].inst;
   assign pc1_o    = rd[0].pc;
   assign inst2_o  = rd[1].inst;
   assign pc2_o    = rd[1].pc;
   assign count_o  = count;

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: a directed vector table, hand-written boundary sequences, and
// random traffic. All of it is checked every cycle against a queue-based model.
module tb_inst_queue;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic        clk, resetn, flush, flush_cause, valid1_i, valid2_i, stall_id, issue_mode_i;
   logic [31:0] ex_pc_i, inst1_i, inst2_i, pc1_i;
   logic        full_o, valid1_o, valid2_o;
   logic [31:0] inst1_o, inst2_o, pc1_o, pc2_o;
   logic [ADDR_W:0] count_o;

   inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .flush_cause(flush_cause),
      .ex_pc_i(ex_pc_i), .valid1_i(valid1_i), .valid2_i(valid2_i),
      .inst1_i(inst1_i), .inst2_i(inst2_i), .pc1_i(pc1_i), .full_o(full_o),
      .stall_id(stall_id), .issue_mode_i(issue_mode_i),
      .inst1_o(inst1_o), .inst2_o(inst2_o), .pc1_o(pc1_o), .pc2_o(pc2_o),
      .valid1_o(valid1_o), .valid2_o(valid2_o), .count_o(count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;
   ent_t q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Expected outputs come from the model contents: oldest two entries and the occupancy.
   task automatic chk_model();
      int sz;
      logic [31:0] e_i1, e_p1, e_i2, e_p2;
      sz = q.size();
      e_i1 = '0; e_p1 = '0; e_i2 = '0; e_p2 = '0;
      if (sz >= 1) begin e_i1 = q[0].inst; e_p1 = q[0].pc; end
      if (sz >= 2) begin e_i2 = q[1].inst; e_p2 = q[1].pc; end
      chk("m_count",  32'(count_o),  32'(sz));
      chk("m_valid1", 32'(valid1_o), 32'(sz >= 1));
      chk("m_valid2", 32'(valid2_o), 32'(sz >= 2));
      chk("m_full",   32'(full_o),   32'(sz > DEPTH - 2));
      chk("m_inst1",  inst1_o, e_i1);
      chk("m_pc1",    pc1_o,   e_p1);
      chk("m_inst2",  inst2_o, e_i2);
      chk("m_pc2",    pc2_o,   e_p2);
   endtask

   task automatic model_update(input logic fl, input logic cause, input logic [31:0] ex,
                               input logic v1, input logic v2, input logic [31:0] i1,
                               input logic [31:0] i2, input logic [31:0] p1,
                               input logic st, input logic md);
      int n, r;
      bit was_full;
      ent_t h;
      if (fl) begin
         if (cause && q.size() > 0 && q[0].pc == ex + 32'd4) begin
            h = q[0];
            q.delete();
            q.push_back(h);
         end else begin
            q.delete();
         end
      end else begin
         was_full = q.size() > DEPTH - 2;
         n = st ? 0 : (md ? 2 : 1);
         r = (n < q.size()) ? n : q.size();
         repeat (r) void'(q.pop_front());
         if (v1 && !was_full) begin
            q.push_back('{i1, p1});
            if (v2) q.push_back('{i2, p1 + 32'd4});
         end
      end
   endtask

   // Drive one cycle: check current state, clock it, advance the model.
   task automatic step(input logic fl, input logic cause, input logic [31:0] ex,
                       input logic v1, input logic v2, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] p1,
                       input logic st, input logic md);
      flush = fl; flush_cause = cause; ex_pc_i = ex;
      valid1_i = v1; valid2_i = v2; inst1_i = i1; inst2_i = i2; pc1_i = p1;
      stall_id = st; issue_mode_i = md;
      chk_model();
      @(posedge clk);
      model_update(fl, cause, ex, v1, v2, i1, i2, p1, st, md);
      #1;
   endtask

   task automatic push2(input logic [31:0] p, input logic st);
      step(0, 0, 0, 1, 1, ~p, p ^ 32'h5a5a0000, p, st, 0);
   endtask

   task automatic pop(input logic md);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, md);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      flush = 0; flush_cause = 0; ex_pc_i = 0; valid1_i = 0; valid2_i = 0;
      inst1_i = 0; inst2_i = 0; pc1_i = 0; stall_id = 1; issue_mode_i = 0;
      q.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   typedef struct {
      logic        fl, cause;
      logic [31:0] ex;
      logic        v1, v2;
      logic [31:0] pc1;
      logic        st, md;
      int          e_cnt;
      logic [31:0] e_pc1, e_pc2;
      logic        e_v2;
   } vec_t;
   vec_t tbl[16];

   initial begin
      tbl[0]  = '{0, 0, 32'h0,        1, 1, 32'hBFC00000, 1, 0, 2, 32'hBFC00000, 32'hBFC00004, 1};
      tbl[1]  = '{0, 0, 32'h0,        1, 1, 32'hBFC00008, 1, 0, 4, 32'hBFC00000, 32'hBFC00004, 1};
      tbl[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 32'hBFC00004, 32'hBFC00008, 1};
      tbl[3]  = '{0, 0, 32'h0,        1, 1, 32'hBFC00010, 0, 1, 3, 32'hBFC0000C, 32'hBFC00010, 1};
      tbl[4]  = '{1, 0, 32'h0,        1, 1, 32'hBFC00300, 0, 1, 0, 32'h0,        32'h0,        0};
      tbl[5]  = '{0, 0, 32'h0,        1, 1, 32'hBFC00108, 1, 0, 2, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[6]  = '{0, 0, 32'h0,        1, 1, 32'hBFC00110, 1, 0, 4, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[7]  = '{0, 0, 32'h0,        1, 0, 32'hBFC00118, 1, 0, 5, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[8]  = '{1, 1, 32'hBFC00104, 1, 1, 32'hBFC00400, 0, 1, 1, 32'hBFC00108, 32'h0,        0};
      tbl[9]  = '{0, 0, 32'h0,        1, 1, 32'hBFC0010C, 1, 0, 3, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[10] = '{0, 0, 32'h0,        1, 1, 32'hBFC00114, 1, 0, 5, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[11] = '{1, 1, 32'hBFC00200, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0};
      tbl[12] = '{0, 0, 32'h0,        1, 1, 32'hBFC00108, 1, 0, 2, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[13] = '{0, 0, 32'h0,        1, 1, 32'hBFC00110, 1, 0, 4, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[14] = '{0, 0, 32'h0,        1, 0, 32'hBFC00118, 1, 0, 5, 32'hBFC00108, 32'hBFC0010C, 1};
      tbl[15] = '{1, 0, 32'hBFC00104, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0};

      do_reset();
      chk("rst_count",  32'(count_o),  0);
      chk("rst_valid1", 32'(valid1_o), 0);
      chk("rst_full",   32'(full_o),   0);
      chk("rst_pc1",    pc1_o,         0);
      pop(1);  // pop request while empty must not underflow
      chk("empty_pop_count", 32'(count_o), 0);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].fl, tbl[i].cause, tbl[i].ex, tbl[i].v1, tbl[i].v2,
              (i == 0) ? 32'h24010001 : 32'h1000 + 32'(i),
              (i == 0) ? 32'h24020002 : 32'h2000 + 32'(i),
              tbl[i].pc1, tbl[i].st, tbl[i].md);
         chk($sformatf("t%0d_count", i), 32'(count_o),  32'(tbl[i].e_cnt));
         chk($sformatf("t%0d_pc1", i),   pc1_o,         tbl[i].e_pc1);
         chk($sformatf("t%0d_pc2", i),   pc2_o,         tbl[i].e_pc2);
         chk($sformatf("t%0d_valid2", i), 32'(valid2_o), 32'(tbl[i].e_v2));
         chk($sformatf("t%0d_full", i),  32'(full_o),   0);
      end

      // Fill to the full boundary, drop a push, then drain through count=1 with dual issue.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push2(32'h8000 + 32'(i * 8), 1);
         if (i == 6) chk("fill7_full", 32'(full_o), 0);
      end
      chk("fill8_count", 32'(count_o), 16);
      chk("fill8_full",  32'(full_o),  1);
      push2(32'h9000, 1);
      chk("drop_count", 32'(count_o), 16);
      step(0, 0, 0, 1, 1, 32'h1, 32'h2, 32'h9100, 0, 1);
      chk("full_pop_count", 32'(count_o), 14);
      chk("full_pop_full",  32'(full_o),  0);
      pop(0);
      for (int i = 0; i < 6; i++) pop(1);
      chk("one_left", 32'(count_o), 1);
      pop(1);
      chk("dual_at_one", 32'(count_o), 0);
      pop(1);
      chk("dual_at_zero", 32'(count_o), 0);

      // Move head/tail to 14, then push across the index wrap and drain in order.
      do_reset();
      for (int i = 0; i < 7; i++) push2(32'h100 + 32'(i * 8), 1);
      for (int i = 0; i < 7; i++) pop(1);
      chk("wrap_empty", 32'(count_o), 0);
      for (int i = 0; i < 3; i++) push2(32'h4000 + 32'(i * 8), 1);
      chk("wrap_count", 32'(count_o), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("wrap_pc%0d", i), pc1_o, 32'h4000 + 32'(i * 4));
         pop(0);
      end
      chk("wrap_drained", 32'(count_o), 0);

      // Asynchronous reset between clock edges.
      push2(32'h7000, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("async_count",  32'(count_o),  0);
      chk("async_valid1", 32'(valid1_o), 0);
      q.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic fl, cause, v1, v2, st, md;
         logic [31:0] ex, p1;
         fl    = ($urandom_range(0, 31) == 0);
         cause = $urandom_range(0, 1);
         ex    = (q.size() > 0 && $urandom_range(0, 1)) ? q[0].pc - 32'd4 : ($urandom() & ~32'h3);
         v1    = ($urandom_range(0, 9) < 7);
         v2    = $urandom_range(0, 1);
         st    = ($urandom_range(0, 3) == 0);
         md    = $urandom_range(0, 1);
         p1    = $urandom() & ~32'h3;
         step(fl, cause, ex, v1, v2, $urandom(), $urandom(), p1, st, md);
      end
      chk_model();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
